// File: rtl/iter_mul_div_unit.sv
// Multi-cycle multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Results land in a HI/LO pair held in dedicated output registers until the next completion.
module iter_mul_div_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [1:0]            req_op,
   input  logic [DATA_WIDTH-1:0] req_a,
   input  logic [DATA_WIDTH-1:0] req_b,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_hi,
   output logic [DATA_WIDTH-1:0] resp_lo,
   output logic                  resp_div_zero,
   output logic                  busy
);

   localparam int W = DATA_WIDTH;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]           state;
   logic [CNT_WIDTH-1:0] cnt;
   logic                 isDiv;
   logic                 negLo;
   logic                 negHi;
   logic                 divZero;
   logic [W-1:0]         accHi;
   logic [W-1:0]         accLo;
   logic [W-1:0]         opB;
   logic [W-1:0]         respHiQ;
   logic [W-1:0]         respLoQ;
   logic                 respDzQ;

   logic [W-1:0]   absA;
   logic [W-1:0]   absB;
   logic           reqSigned;
   logic [W:0]     mulSum;
   logic [W:0]     divShift;
   logic [W:0]     divTrial;
   logic           divGe;
   logic [W-1:0]   stepHi;
   logic [W-1:0]   stepLo;
   logic [2*W-1:0] prodNeg;
   logic [W-1:0]   finalHi;
   logic [W-1:0]   finalLo;

   always_comb begin
      reqSigned = req_op[0];
      absA      = (reqSigned && req_a[W-1]) ? -req_a : req_a;
      absB      = (reqSigned && req_b[W-1]) ? -req_b : req_b;

      // Multiply: accLo holds the shifting multiplier, product bits enter from the top.
      mulSum = {1'b0, accHi} + (accLo[0] ? {1'b0, opB} : {(W + 1){1'b0}});

      // Divide: partial remainder in accHi, quotient bits shift into accLo.
      divShift = {accHi, accLo[W-1]};
      divGe    = divShift >= {1'b0, opB};
      divTrial = divShift - {1'b0, opB};

      if (isDiv) begin
         stepHi = divGe ? divTrial[W-1:0] : divShift[W-1:0];
         stepLo = {accLo[W-2:0], divGe};
      end else begin
         stepHi = mulSum[W:1];
         stepLo = {mulSum[0], accLo[W-1:1]};
      end

      prodNeg = -{stepHi, stepLo};
      if (isDiv) begin
         finalHi = negHi ? -stepHi : stepHi;
         finalLo = negLo ? -stepLo : stepLo;
      end else if (negLo) begin
         finalHi = prodNeg[2*W-1:W];
         finalLo = prodNeg[W-1:0];
      end else begin
         finalHi = stepHi;
         finalLo = stepLo;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         isDiv   <= 1'b0;
         negLo   <= 1'b0;
         negHi   <= 1'b0;
         divZero <= 1'b0;
         accHi   <= '0;
         accLo   <= '0;
         opB     <= '0;
         respHiQ <= '0;
         respLoQ <= '0;
         respDzQ <= 1'b0;
      end else if (flush) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  state   <= RUN;
                  cnt     <= CNT_WIDTH'(W);
                  isDiv   <= req_op[1];
                  // negLo: product or quotient sign; negHi: remainder sign.
                  negLo   <= reqSigned && (req_a[W-1] ^ req_b[W-1]);
                  negHi   <= reqSigned && req_a[W-1];
                  divZero <= req_op[1] && (req_b == '0);
                  // On divide-by-zero accHi carries the raw dividend through to HI.
                  accHi   <= (req_op[1] && (req_b == '0)) ? req_a : '0;
                  accLo   <= absA;
                  opB     <= absB;
               end
            end
            RUN: begin
               if (divZero) begin
                  respHiQ <= accHi;
                  respLoQ <= '1;
                  respDzQ <= 1'b1;
                  state   <= DONE;
               end else begin
                  accHi <= stepHi;
                  accLo <= stepLo;
                  cnt   <= cnt - CNT_WIDTH'(1);
                  if (cnt == CNT_WIDTH'(1)) begin
                     respHiQ <= finalHi;
                     respLoQ <= finalLo;
                     respDzQ <= 1'b0;
                     state   <= DONE;
                  end
               end
            end
            DONE: begin
               if (resp_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign req_ready     = (state == IDLE);
   assign resp_valid    = (state == DONE);
   assign busy          = (state != IDLE);
   assign resp_hi       = respHiQ;
   assign resp_lo       = respLoQ;
   assign resp_div_zero = respDzQ;

endmodule

// File: tb/tb_iter_mul_div_unit.sv
// Directed bench for iter_mul_div_unit: an 8-bit instance for most vectors and a
// 32-bit instance for the held-response case.
module tb_iter_mul_div_unit;

   localparam logic [1:0] MULTU = 2'd0;
   localparam logic [1:0] MULT  = 2'd1;
   localparam logic [1:0] DIVU  = 2'd2;
   localparam logic [1:0] DIV   = 2'd3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic flush = 1'b0;

   logic       rv8 = 1'b0, rr8 = 1'b0;
   logic [1:0] op8 = '0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       ready8, valid8, dz8, busy8;
   logic [7:0] hi8, lo8;

   logic        rv32 = 1'b0, rr32 = 1'b0;
   logic [1:0]  op32 = '0;
   logic [31:0] a32 = '0, b32 = '0;
   logic        ready32, valid32, dz32, busy32;
   logic [31:0] hi32, lo32;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   iter_mul_div_unit #(.DATA_WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .flush(flush),
      .req_valid(rv8), .req_ready(ready8), .req_op(op8), .req_a(a8), .req_b(b8),
      .resp_valid(valid8), .resp_ready(rr8), .resp_hi(hi8), .resp_lo(lo8),
      .resp_div_zero(dz8), .busy(busy8)
   );

   iter_mul_div_unit #(.DATA_WIDTH(32)) dut32 (
      .clk(clk), .rst(rst), .flush(flush),
      .req_valid(rv32), .req_ready(ready32), .req_op(op32), .req_a(a32), .req_b(b32),
      .resp_valid(valid32), .resp_ready(rr32), .resp_hi(hi32), .resp_lo(lo32),
      .resp_div_zero(dz32), .busy(busy32)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Presents a request on the 8-bit unit for one accept edge, then scrambles the operands.
   task automatic start8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
      rv8 = 1'b1;
      op8 = op;
      a8  = a;
      b8  = b;
      check("ready_before_accept", ready8, 1);
      tick();
      rv8 = 1'b0;
      a8  = 8'($urandom);
      b8  = 8'($urandom);
   endtask

   task automatic run8(input string tag, input logic [1:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] expHi, input logic [7:0] expLo,
                       input logic expDz, input int lat);
      start8(op, a, b);
      repeat (lat - 2) tick();
      check({tag, "_early_valid"}, valid8, 0);
      tick();
      check({tag, "_valid"}, valid8, 1);
      check({tag, "_hi"}, hi8, expHi);
      check({tag, "_lo"}, lo8, expLo);
      check({tag, "_dz"}, dz8, expDz);
      check({tag, "_ready_in_done"}, ready8, 0);
      rr8 = 1'b1;
      tick();
      rr8 = 1'b0;
      check({tag, "_valid_drop"}, valid8, 0);
      check({tag, "_ready_back"}, ready8, 1);
   endtask

   initial begin
      logic sawValid;

      tick();
      tick();
      rst = 1'b0;
      check("rst_ready", ready8, 1);
      check("rst_valid", valid8, 0);
      check("rst_hi", hi8, 0);
      check("rst_lo", lo8, 0);
      check("rst_dz", dz8, 0);
      check("rst_busy", busy8, 0);

      run8("multu_ff_ff", MULTU, 8'hFF, 8'hFF, 8'hFE, 8'h01, 1'b0, 9);
      check("hold_in_idle_hi", hi8, 8'hFE);
      run8("mult_m3_5", MULT, 8'hFD, 8'h05, 8'hFF, 8'hF1, 1'b0, 9);
      run8("mult_m128_m128", MULT, 8'h80, 8'h80, 8'h40, 8'h00, 1'b0, 9);
      run8("div_m7_2", DIV, 8'hF9, 8'h02, 8'hFF, 8'hFD, 1'b0, 9);
      run8("divu_2a_0", DIVU, 8'h2A, 8'h00, 8'h2A, 8'hFF, 1'b1, 2);
      run8("div_m7_0", DIV, 8'hF9, 8'h00, 8'hF9, 8'hFF, 1'b1, 2);
      run8("div_ovf", DIV, 8'h80, 8'hFF, 8'h00, 8'h80, 1'b0, 9);
      run8("divu_c8_0d", DIVU, 8'hC8, 8'h0D, 8'h05, 8'h0F, 1'b0, 9);

      // Flush mid-RUN at accept+3.
      start8(MULTU, 8'h12, 8'h34);
      tick();
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_run_ready", ready8, 1);
      check("flush_run_busy", busy8, 0);
      sawValid = valid8;
      for (int i = 0; i < 12; i++) begin
         tick();
         sawValid = sawValid | valid8;
      end
      check("flush_run_no_valid", sawValid, 0);
      run8("after_flush", MULTU, 8'h12, 8'h34, 8'h03, 8'hA8, 1'b0, 9);

      // Flush in IDLE blocks a concurrent request.
      rv8   = 1'b1;
      op8   = MULTU;
      flush = 1'b1;
      tick();
      rv8   = 1'b0;
      flush = 1'b0;
      check("flush_idle_busy", busy8, 0);
      tick();
      check("flush_idle_valid", valid8, 0);

      // Flush in DONE discards the response; outputs keep last values.
      start8(MULTU, 8'h03, 8'h03);
      repeat (8) tick();
      check("flush_done_pre_valid", valid8, 1);
      check("flush_done_pre_lo", lo8, 8'h09);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_done_valid", valid8, 0);
      check("flush_done_ready", ready8, 1);
      check("flush_done_lo_held", lo8, 8'h09);

      // Reset mid-RUN.
      start8(MULT, 8'hFD, 8'h05);
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_run_valid", valid8, 0);
      check("rst_run_lo", lo8, 0);
      check("rst_run_busy", busy8, 0);
      check("rst_run_ready", ready8, 1);

      // Reset together with flush in DONE.
      start8(DIVU, 8'h2A, 8'h00);
      tick();
      check("rst_done_pre_valid", valid8, 1);
      check("rst_done_pre_dz", dz8, 1);
      rst   = 1'b1;
      flush = 1'b1;
      tick();
      rst   = 1'b0;
      flush = 1'b0;
      check("rst_done_valid", valid8, 0);
      check("rst_done_hi", hi8, 0);
      check("rst_done_lo", lo8, 0);
      check("rst_done_dz", dz8, 0);
      check("rst_done_busy", busy8, 0);
      check("rst_done_ready", ready8, 1);

      // 32-bit DIVU 100/7 with the response held off for 5 cycles.
      rv32 = 1'b1;
      op32 = DIVU;
      a32  = 32'd100;
      b32  = 32'd7;
      check("w32_ready", ready32, 1);
      tick();
      rv32 = 1'b0;
      a32  = 32'hDEAD_BEEF;
      b32  = 32'd0;
      repeat (31) tick();
      check("w32_early_valid", valid32, 0);
      tick();
      for (int i = 0; i < 5; i++) begin
         check("w32_hold_valid", valid32, 1);
         check("w32_hold_lo", lo32, 32'd14);
         check("w32_hold_hi", hi32, 32'd2);
         check("w32_hold_ready", ready32, 0);
         if (i < 4) tick();
      end
      rr32 = 1'b1;
      tick();
      rr32 = 1'b0;
      check("w32_valid_drop", valid32, 0);
      check("w32_ready_back", ready32, 1);
      check("w32_busy", busy32, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
